// File: rtl/seven_seg_scanner_if.sv
// Display-side bundle for the 7-segment scanner: digit data and update strobe in,
// registered segment/anode drive and frame pulse out.
interface seven_seg_scanner_if;
  logic [15:0] value;
  logic [3:0]  blank;
  logic [3:0]  dash;
  logic [3:0]  dp;
  logic        update;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  anode;
  logic        frame_done;

  modport master (
    output value, blank, dash, dp, update,
    input  seg, dp_n, anode, frame_done
  );

  modport slave (
    input  value, blank, dash, dp, update,
    output seg, dp_n, anode, frame_done
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Multiplexed 4-digit common-anode 7-segment driver with frame-synchronous
// double buffering and an anode dead-time at every digit change.
module seven_seg_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  seven_seg_scanner_if.slave bus
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST_TICK = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_reg;
  logic [1:0]    idx_reg;

  logic [15:0] pend_value_reg, act_value_reg;
  logic [3:0]  pend_blank_reg, act_blank_reg;
  logic [3:0]  pend_dash_reg,  act_dash_reg;
  logic [3:0]  pend_dp_reg,    act_dp_reg;
  logic        pend_valid_reg;

  logic [6:0] seg_reg;
  logic       dp_n_reg;
  logic [3:0] anode_reg;
  logic       wrap_reg;
  logic       frame_done_reg;

  logic       slot_wrap;
  logic       boundary;
  logic [3:0] nib [4];
  logic [3:0] sel_nib;
  logic       sel_blank;
  logic       sel_dash;
  logic       sel_dp;
  logic [6:0] seg_next;
  logic       dp_n_next;
  logic [3:0] anode_next;

  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    case (h)
      4'h0:    hex_seg = 7'b1000000;
      4'h1:    hex_seg = 7'b1111001;
      4'h2:    hex_seg = 7'b0100100;
      4'h3:    hex_seg = 7'b0110000;
      4'h4:    hex_seg = 7'b0011001;
      4'h5:    hex_seg = 7'b0010010;
      4'h6:    hex_seg = 7'b0000010;
      4'h7:    hex_seg = 7'b1111000;
      4'h8:    hex_seg = 7'b0000000;
      4'h9:    hex_seg = 7'b0011000;
      4'hA:    hex_seg = 7'b0001000;
      4'hB:    hex_seg = 7'b0000011;
      4'hC:    hex_seg = 7'b1000110;
      4'hD:    hex_seg = 7'b0100001;
      4'hE:    hex_seg = 7'b0000110;
      default: hex_seg = 7'b0001110;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib
      assign nib[gi] = act_value_reg[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    slot_wrap = (cnt_reg == LAST_TICK);
    boundary  = slot_wrap && (idx_reg == 2'd3);
    sel_nib   = nib[idx_reg];
    sel_blank = act_blank_reg[idx_reg];
    sel_dash  = act_dash_reg[idx_reg];
    sel_dp    = act_dp_reg[idx_reg];
    if (sel_blank)
      seg_next = 7'b1111111;
    else if (sel_dash)
      seg_next = 7'b0111111;
    else
      seg_next = hex_seg(sel_nib);
    dp_n_next = ~(sel_dp & ~sel_blank);
    // seg/dp_n switch to the new digit while anodes are still dark
    if (cnt_reg < BLANK_END)
      anode_next = 4'b1111;
    else
      anode_next = ~(4'b0001 << idx_reg);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg        <= '0;
      idx_reg        <= 2'd0;
      pend_valid_reg <= 1'b0;
      pend_value_reg <= 16'h0000;
      pend_blank_reg <= 4'b1111;
      pend_dash_reg  <= 4'b0000;
      pend_dp_reg    <= 4'b0000;
      act_value_reg  <= 16'h0000;
      act_blank_reg  <= 4'b1111;
      act_dash_reg   <= 4'b0000;
      act_dp_reg     <= 4'b0000;
      seg_reg        <= 7'b1111111;
      dp_n_reg       <= 1'b1;
      anode_reg      <= 4'b1111;
      wrap_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      cnt_reg <= slot_wrap ? '0 : cnt_reg + 1'b1;
      if (slot_wrap)
        idx_reg <= idx_reg + 2'd1;

      // A strobe on the boundary itself bypasses (and discards) the pending copy
      if (boundary) begin
        if (bus.update) begin
          act_value_reg  <= bus.value;
          act_blank_reg  <= bus.blank;
          act_dash_reg   <= bus.dash;
          act_dp_reg     <= bus.dp;
          pend_valid_reg <= 1'b0;
        end else if (pend_valid_reg) begin
          act_value_reg  <= pend_value_reg;
          act_blank_reg  <= pend_blank_reg;
          act_dash_reg   <= pend_dash_reg;
          act_dp_reg     <= pend_dp_reg;
          pend_valid_reg <= 1'b0;
        end
      end else if (bus.update) begin
        pend_value_reg <= bus.value;
        pend_blank_reg <= bus.blank;
        pend_dash_reg  <= bus.dash;
        pend_dp_reg    <= bus.dp;
        pend_valid_reg <= 1'b1;
      end

      seg_reg        <= seg_next;
      dp_n_reg       <= dp_n_next;
      anode_reg      <= anode_next;
      // Delayed one extra cycle so the pulse lines up with digit 0 on the outputs
      wrap_reg       <= boundary;
      frame_done_reg <= wrap_reg;
    end
  end

  assign bus.seg        = seg_reg;
  assign bus.dp_n       = dp_n_reg;
  assign bus.anode      = anode_reg;
  assign bus.frame_done = frame_done_reg;

endmodule
